// File: rtl/macro_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : macro_encoder_pkg
// Description : Shared types and sizing helpers for the encoder macros.
//               Tree node {q, c, idx}, index-width and pipeline-depth helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package macro_encoder_pkg;

  // Index field wide enough for vectors up to 2^16 bits; unused upper bits stay 0.
  localparam int c_NODE_IDX_W = 16;

  typedef struct packed {
    logic                    q;    // at least one bit set below this node
    logic                    c;    // two or more bits set below this node
    logic [c_NODE_IDX_W-1:0] idx;  // index of lowest set bit below this node
  } node_t;

  // max(1, clog2(n))
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // max(1, ceil(levels / levels_per_stage)) with levels = clog2(width)
  function automatic int stage_count(input int width, input int lps);
    int l;
    int s;
    l = (width <= 1) ? 0 : $clog2(width);
    s = (l + lps - 1) / lps;
    return (s < 1) ? 1 : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/macro_encoder_onehot_check_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : macro_encoder_onehot_check_pipe_if
// Description : Handshake, result and error-status bundle of the one-hot
//               checker. master = producer/consumer side, slave = checker.
// Revision    : 1.0 - initial release
// ============================================================================
interface macro_encoder_onehot_check_pipe_if #(
  parameter int INPUT_WIDTH = 8,
  parameter int CNT_WIDTH   = 8,
  parameter int IDX_W       = macro_encoder_pkg::idx_width(INPUT_WIDTH)
);
  logic                   i_valid;
  logic                   i_ready;
  logic [INPUT_WIDTH-1:0] i_d;
  logic                   o_valid_out;
  logic                   o_ready_out;
  logic                   o_valid;
  logic                   o_zero;
  logic                   o_multi;
  logic [IDX_W-1:0]       o_idx;
  logic                   clr;
  logic                   err_sticky;
  logic [CNT_WIDTH-1:0]   err_cnt;

  modport master (
    output i_valid, i_d, o_ready_out, clr,
    input  i_ready, o_valid_out, o_valid, o_zero, o_multi, o_idx, err_sticky, err_cnt
  );

  modport slave (
    input  i_valid, i_d, o_ready_out, clr,
    output i_ready, o_valid_out, o_valid, o_zero, o_multi, o_idx, err_sticky, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/macro_encoder_onehot_check_node.sv
`default_nettype none
// ============================================================================
// Module      : macro_encoder_onehot_check_node
// Description : Combinational 2:1 reduction node of the one-hot tree.
//               Child a covers the lower bit indices and wins the index.
//               Index logic present only with MACRO_ENCODER_ONEHOT_CHECK_IDX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module macro_encoder_onehot_check_node
  import macro_encoder_pkg::*;
#(
  parameter int LVL = 0  // bit position of the new index bit (child index width)
) (
  input  node_t a,
  input  node_t b,
  output node_t y
);

  // Merge presence/collision flags and prepend the half-select bit to the index.
  always_comb begin
    y     = '0;
    y.q   = a.q | b.q;
    y.c   = a.c | b.c | (a.q & b.q);
`ifdef MACRO_ENCODER_ONEHOT_CHECK_IDX_EN
    y.idx      = a.q ? a.idx : b.idx;
    y.idx[LVL] = ~a.q;
`endif
  end

`ifndef MACRO_ENCODER_ONEHOT_CHECK_IDX_EN
  logic w_unused_idx;
  assign w_unused_idx = ^{a.idx, b.idx};
`endif

endmodule
`default_nettype wire

// File: rtl/macro_encoder_onehot_check_pipe.sv
`default_nettype none
// ============================================================================
// Module      : macro_encoder_onehot_check_pipe
// Description : Pipelined, back-pressured one-hot checker/encoder with sticky
//               error flag and saturating violation counter.
//               Optional macro MACRO_ENCODER_ONEHOT_CHECK_IDX_EN carries the
//               encoded index through the pipeline; without it o_idx is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module macro_encoder_onehot_check_pipe
  import macro_encoder_pkg::*;
#(
  parameter int INPUT_WIDTH      = 8,
  parameter int LEVELS_PER_STAGE = 1,
  parameter bit ALLOW_ZERO       = 1'b0,
  parameter int CNT_WIDTH        = 8
) (
  input logic                             clk,
  input logic                             resetn,
  macro_encoder_onehot_check_pipe_if.slave bus
);

  localparam int c_L     = (INPUT_WIDTH <= 1) ? 0 : $clog2(INPUT_WIDTH);
  localparam int c_P     = 1 << c_L;
  localparam int c_NSTG  = stage_count(INPUT_WIDTH, LEVELS_PER_STAGE);
  localparam int c_IDX_W = idx_width(INPUT_WIDTH);
  // All tree levels flattened: level k occupies [2P-2(P>>k) +: P>>k].
  localparam int c_NODES = 2 * c_P - 1;

  node_t                w_comb [c_NODES];
  node_t                w_src  [c_NODES];
  node_t                w_final;
  logic                 w_adv;
  logic                 w_legal;
  logic                 w_viol;
  logic [c_NSTG:0]      w_vld_chain;
  logic [c_NSTG-1:0]    r_vld;
  logic                 r_sticky;
  logic [CNT_WIDTH-1:0] r_cnt;

  // Global stall: every stage moves only when the output slot is free or taken.
  assign w_adv       = ~r_vld[c_NSTG-1] | bus.o_ready_out;
  assign bus.i_ready = w_adv;
  assign w_vld_chain = {r_vld, bus.i_valid};

  // Per-stage valid bits shift together; bubbles are kept, not collapsed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld <= w_vld_chain[c_NSTG-1:0];
    end
  end

  for (genvar k = 0; k <= c_L; k++) begin : g_lvl
    localparam int c_OFF = 2 * c_P - 2 * (c_P >> k);
    localparam int c_N   = c_P >> k;
    localparam bit c_BND = (k == c_L) || ((k > 0) && ((k % LEVELS_PER_STAGE) == 0));

    if (k == 0) begin : g_leaf
      for (genvar j = 0; j < c_N; j++) begin : g_bit
        if (j < INPUT_WIDTH) begin : g_in
          assign w_comb[j] = '{q: bus.i_d[j], c: 1'b0, idx: '0};
        end else begin : g_pad
          assign w_comb[j] = '0;
        end
      end
    end else begin : g_tree
      localparam int c_PREV = 2 * c_P - 2 * (c_P >> (k - 1));
      for (genvar j = 0; j < c_N; j++) begin : g_node
        macro_encoder_onehot_check_node #(
          .LVL(k - 1)
        ) u_node (
          .a(w_src[c_PREV + 2 * j]),
          .b(w_src[c_PREV + 2 * j + 1]),
          .y(w_comb[c_OFF + j])
        );
      end
    end

    if (c_BND) begin : g_reg
      node_t r_node [c_N];
      // Stage register: captures whenever the pipe advances, valid or not.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < c_N; i++) r_node[i] <= '0;
        end else if (w_adv) begin
          for (int i = 0; i < c_N; i++) r_node[i] <= w_comb[c_OFF + i];
        end
      end
      for (genvar j = 0; j < c_N; j++) begin : g_out
        assign w_src[c_OFF + j] = r_node[j];
      end
    end else begin : g_thru
      for (genvar j = 0; j < c_N; j++) begin : g_wire
        assign w_src[c_OFF + j] = w_comb[c_OFF + j];
      end
    end
  end

  assign w_final = w_src[c_NODES-1];
  assign w_legal = (w_final.q & ~w_final.c) | (ALLOW_ZERO & ~w_final.q);
  assign w_viol  = r_vld[c_NSTG-1] & bus.o_ready_out & ~w_legal;

  // Status is qualified by the output valid so an empty slot reads all-zero.
  assign bus.o_valid_out = r_vld[c_NSTG-1];
  assign bus.o_valid     = r_vld[c_NSTG-1] & w_legal;
  assign bus.o_zero      = r_vld[c_NSTG-1] & ~w_final.q;
  assign bus.o_multi     = r_vld[c_NSTG-1] & w_final.c;
`ifdef MACRO_ENCODER_ONEHOT_CHECK_IDX_EN
  assign bus.o_idx = (r_vld[c_NSTG-1] & w_final.q) ? w_final.idx[c_IDX_W-1:0] : '0;
`else
  assign bus.o_idx = '0;
`endif

  logic w_unused_final;
  assign w_unused_final = ^w_final.idx;

  // Error tracking on delivered results; clr wins over the held value only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (bus.clr) begin
      r_sticky <= w_viol;
      r_cnt    <= w_viol ? CNT_WIDTH'(1) : '0;
    end else if (w_viol) begin
      r_sticky <= 1'b1;
      if (r_cnt != {CNT_WIDTH{1'b1}}) r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.err_sticky = r_sticky;
  assign bus.err_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_macro_encoder_onehot_check_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_macro_encoder_onehot_check_pipe
// Description : Scoreboard bench: W=8/LPS=1/CNT=4 checker plus a W=1,
//               ALLOW_ZERO=1 instance. Index expectations follow
//               MACRO_ENCODER_ONEHOT_CHECK_IDX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_macro_encoder_onehot_check_pipe;

`ifdef MACRO_ENCODER_ONEHOT_CHECK_IDX_EN
  localparam bit IDX_ON = 1'b1;
`else
  localparam bit IDX_ON = 1'b0;
`endif

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_err  = 0;
  int   n_deliv0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       v;
    logic       z;
    logic       m;
    logic [2:0] idx;
    bit         chk_lat;
    int         issue;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  macro_encoder_onehot_check_pipe_if #(.INPUT_WIDTH(8), .CNT_WIDTH(4)) bus0 ();
  macro_encoder_onehot_check_pipe_if #(.INPUT_WIDTH(1), .CNT_WIDTH(4)) bus1 ();

  macro_encoder_onehot_check_pipe #(
    .INPUT_WIDTH(8), .LEVELS_PER_STAGE(1), .ALLOW_ZERO(1'b0), .CNT_WIDTH(4)
  ) u_dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0)
  );

  macro_encoder_onehot_check_pipe #(
    .INPUT_WIDTH(1), .LEVELS_PER_STAGE(1), .ALLOW_ZERO(1'b1), .CNT_WIDTH(4)
  ) u_dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Monitor for the 8-bit instance: compare every delivered result.
  always @(negedge clk) begin : mon0
    exp_t e;
    #1;
    if (resetn && bus0.o_valid_out && bus0.o_ready_out) begin
      n_deliv0++;
      if (q0.size() == 0) fail("unexpected_result0");
      else begin
        e = q0.pop_front();
        chk("o_valid", bus0.o_valid, e.v);
        chk("o_zero", bus0.o_zero, e.z);
        chk("o_multi", bus0.o_multi, e.m);
        chk("o_idx", bus0.o_idx, IDX_ON ? e.idx : 3'd0);
        if (e.chk_lat) chk("latency", cyc - e.issue + 1, 3);
      end
    end
  end

  // Monitor for the 1-bit instance.
  always @(negedge clk) begin : mon1
    exp_t e;
    #1;
    if (resetn && bus1.o_valid_out && bus1.o_ready_out) begin
      if (q1.size() == 0) fail("unexpected_result1");
      else begin
        e = q1.pop_front();
        chk("w1_o_valid", bus1.o_valid, e.v);
        chk("w1_o_zero", bus1.o_zero, e.z);
        chk("w1_o_multi", bus1.o_multi, e.m);
        chk("w1_o_idx", bus1.o_idx, e.idx[0]);
        if (e.chk_lat) chk("w1_latency", cyc - e.issue + 1, 1);
      end
    end
  end

  // Present one vector at a negedge, wait for acceptance, log the expectation.
  task automatic send0(input logic [7:0] d, input bit push, input logic v, input logic z,
                       input logic m, input logic [2:0] idx, input bit lat);
    int   g;
    exp_t e;
    bus0.i_valid = 1'b1;
    bus0.i_d     = d;
    #1;
    g = 0;
    while (!bus0.i_ready && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 100) fail("send0_timeout");
    if (push) begin
      e.v = v; e.z = z; e.m = m; e.idx = idx; e.chk_lat = lat; e.issue = cyc + 1;
      q0.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic send1(input logic d, input logic v, input logic z);
    exp_t e;
    bus1.i_valid = 1'b1;
    bus1.i_d     = d;
    e.v = v; e.z = z; e.m = 1'b0; e.idx = 3'd0; e.chk_lat = 1'b1; e.issue = cyc + 1;
    q1.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain0();
    int g;
    g = 0;
    while (q0.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) fail("drain0_timeout");
    @(negedge clk);
    #2;
  endtask

  task automatic drain1();
    int g;
    g = 0;
    while (q1.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) fail("drain1_timeout");
    @(negedge clk);
    #2;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int g;
    int d_before;
    bus0.i_valid = 1'b0; bus0.i_d = '0; bus0.o_ready_out = 1'b1; bus0.clr = 1'b0;
    bus1.i_valid = 1'b0; bus1.i_d = '0; bus1.o_ready_out = 1'b1; bus1.clr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_i_ready", bus0.i_ready, 1);
    chk("rst_o_valid_out", bus0.o_valid_out, 0);
    chk("rst_o_zero", bus0.o_zero, 0);
    chk("rst_err_cnt", bus0.err_cnt, 0);
    chk("rst_err_sticky", bus0.err_sticky, 0);

    // One-hot vector, 3-cycle latency
    @(negedge clk);
    send0(8'h10, 1, 1, 0, 0, 3'd4, 1);
    bus0.i_valid = 1'b0;
    drain0();
    chk("t1_err_cnt", bus0.err_cnt, 0);
    chk("t1_sticky", bus0.err_sticky, 0);

    // All-zero vector is a violation
    @(negedge clk);
    send0(8'h00, 1, 0, 1, 0, 3'd0, 1);
    bus0.i_valid = 1'b0;
    drain0();
    chk("t2_err_cnt", bus0.err_cnt, 1);
    chk("t2_sticky", bus0.err_sticky, 1);

    // Top bit one-hot
    @(negedge clk);
    send0(8'h80, 1, 1, 0, 0, 3'd7, 1);
    bus0.i_valid = 1'b0;
    drain0();
    chk("t2b_err_cnt", bus0.err_cnt, 1);

    // Multi-hot held under back-pressure
    @(negedge clk);
    bus0.o_ready_out = 1'b0;
    send0(8'h24, 1, 0, 0, 1, 3'd2, 0);
    bus0.i_valid = 1'b0;
    g = 0;
    while (!bus0.o_valid_out && g < 20) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 20) fail("t3_wait_timeout");
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid_out", bus0.o_valid_out, 1);
      chk("t3_hold_multi", bus0.o_multi, 1);
      chk("t3_hold_idx", bus0.o_idx, IDX_ON ? 3'd2 : 3'd0);
      chk("t3_hold_i_ready", bus0.i_ready, 0);
      chk("t3_hold_err_cnt", bus0.err_cnt, 1);
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    bus0.o_ready_out = 1'b1;
    drain0();
    chk("t3_err_cnt", bus0.err_cnt, 2);

    // Saturation with a back-to-back stream of all-ones
    @(negedge clk);
    for (int i = 0; i < 20; i++) send0(8'hFF, 1, 0, 0, 1, 3'd0, 1);
    bus0.i_valid = 1'b0;
    drain0();
    chk("t4_err_cnt_sat", bus0.err_cnt, 15);
    chk("t4_sticky", bus0.err_sticky, 1);

    // Reset with three vectors in flight
    @(negedge clk);
    bus0.o_ready_out = 1'b0;
    send0(8'h01, 0, 0, 0, 0, 3'd0, 0);
    send0(8'h02, 0, 0, 0, 0, 3'd0, 0);
    send0(8'h04, 0, 0, 0, 0, 3'd0, 0);
    bus0.i_valid = 1'b0;
    #1;
    chk("t5_pre_valid_out", bus0.o_valid_out, 1);
    resetn = 1'b0;
    #1;
    chk("t5_valid_out", bus0.o_valid_out, 0);
    chk("t5_o_valid", bus0.o_valid, 0);
    chk("t5_err_cnt", bus0.err_cnt, 0);
    chk("t5_sticky", bus0.err_sticky, 0);
    chk("t5_i_ready", bus0.i_ready, 1);
    @(negedge clk);
    resetn = 1'b1;
    bus0.o_ready_out = 1'b1;
    d_before = n_deliv0;
    repeat (6) @(negedge clk);
    #2;
    chk("t5_no_delivery", n_deliv0 - d_before, 0);

    // clr coinciding with a delivered violation
    @(negedge clk);
    send0(8'h00, 1, 0, 1, 0, 3'd0, 1);
    bus0.i_valid = 1'b0;
    drain0();
    chk("t6_pre_cnt", bus0.err_cnt, 1);
    @(negedge clk);
    send0(8'h00, 1, 0, 1, 0, 3'd0, 1);
    bus0.i_valid = 1'b0;
    g = 0;
    while (!bus0.o_valid_out && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) fail("t6_wait_timeout");
    bus0.clr = 1'b1;
    @(negedge clk);
    bus0.clr = 1'b0;
    #2;
    chk("t6_clr_viol_cnt", bus0.err_cnt, 1);
    chk("t6_clr_viol_sticky", bus0.err_sticky, 1);
    @(negedge clk);
    bus0.clr = 1'b1;
    @(negedge clk);
    bus0.clr = 1'b0;
    #2;
    chk("t6_clr_cnt", bus0.err_cnt, 0);
    chk("t6_clr_sticky", bus0.err_sticky, 0);

    // Single-bit instance with zero allowed
    @(negedge clk);
    send1(1'b1, 1, 0);
    send1(1'b0, 1, 1);
    bus1.i_valid = 1'b0;
    drain1();
    chk("w1_err_cnt", bus1.err_cnt, 0);
    chk("w1_sticky", bus1.err_sticky, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
